// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection and bubble counting.
// Drives the ALU operands and control code one cycle after ID presents an instruction.
module id_ex_operand_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned REGA = 5,
   parameter int unsigned CntW = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            id_valid_i,
   input  logic [REGA-1:0] id_rs1_i,
   input  logic [REGA-1:0] id_rs2_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic            id_alusrc_i,
   input  logic            id_uses_rs2_i,
   input  logic [3:0]      id_ctrl_i,
   input  logic [REGA-1:0] id_rd_i,
   input  logic            id_regwrite_i,
   input  logic            id_memread_i,
   input  logic            id_memwrite_i,
   input  logic            id_memtoreg_i,
   input  logic            exmem_regwrite_i,
   input  logic [REGA-1:0] exmem_rd_i,
   input  logic [XLEN-1:0] exmem_result_i,
   input  logic            memwb_regwrite_i,
   input  logic [REGA-1:0] memwb_rd_i,
   input  logic [XLEN-1:0] memwb_result_i,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] data1_o,
   output logic [XLEN-1:0] data2_o,
   output logic [3:0]      ctrl_o,
   output logic [XLEN-1:0] store_data_o,
   output logic [REGA-1:0] rd_o,
   output logic            regwrite_o,
   output logic            memread_o,
   output logic            memwrite_o,
   output logic            memtoreg_o,
   output logic            valid_o,
   output logic            hazard_o,
   output logic [15:0]     bubble_cnt_o
);

   typedef struct packed {
      logic            valid;
      logic [REGA-1:0] rs1;
      logic [REGA-1:0] rs2;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic            alusrc;
      logic [3:0]      ctrl;
      logic [REGA-1:0] rd;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
   } stage_t;

   stage_t            stage_q, stage_d, id_fields;
   logic [CntW-1:0]   bubble_cnt_q, bubble_cnt_d;
   logic              hazard;
   logic              bubble_ins;
   logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

   always_comb begin
      id_fields.valid    = id_valid_i;
      id_fields.rs1      = id_rs1_i;
      id_fields.rs2      = id_rs2_i;
      id_fields.rs1_data = id_rs1_data_i;
      id_fields.rs2_data = id_rs2_data_i;
      id_fields.imm      = id_imm_i;
      id_fields.alusrc   = id_alusrc_i;
      id_fields.ctrl     = id_ctrl_i;
      id_fields.rd       = id_rd_i;
      id_fields.regwrite = id_regwrite_i;
      id_fields.memread  = id_memread_i;
      id_fields.memwrite = id_memwrite_i;
      id_fields.memtoreg = id_memtoreg_i;
   end

   // Load in EX whose destination is read by the instruction waiting in ID.
   always_comb begin
      hazard = stage_q.valid & stage_q.memread & (stage_q.rd != '0) & id_valid_i &
               ((stage_q.rd == id_rs1_i) | (id_uses_rs2_i & (stage_q.rd == id_rs2_i)));
   end

   always_comb begin
      stage_d    = stage_q;
      bubble_ins = 1'b0;
      if (flush_i) begin
         stage_d = '0;
      end else if (stall_i) begin
         stage_d = stage_q;
      end else if (hazard) begin
         stage_d    = '0;
         bubble_ins = 1'b1;
      end else begin
         stage_d = id_fields;
      end
   end

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_ins && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q      <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stage_q      <= stage_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // EX/MEM is the younger result, so it takes precedence; x0 is never forwarded.
   always_comb begin
      if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs1)) begin
         fwd_rs1 = exmem_result_i;
      end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs1)) begin
         fwd_rs1 = memwb_result_i;
      end else begin
         fwd_rs1 = stage_q.rs1_data;
      end
      if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs2)) begin
         fwd_rs2 = exmem_result_i;
      end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs2)) begin
         fwd_rs2 = memwb_result_i;
      end else begin
         fwd_rs2 = stage_q.rs2_data;
      end
   end

   assign data1_o      = fwd_rs1;
   assign data2_o      = stage_q.alusrc ? stage_q.imm : fwd_rs2;
   assign store_data_o = fwd_rs2;
   assign ctrl_o       = stage_q.ctrl;
   assign rd_o         = stage_q.rd;
   assign regwrite_o   = stage_q.regwrite;
   assign memread_o    = stage_q.memread;
   assign memwrite_o   = stage_q.memwrite;
   assign memtoreg_o   = stage_q.memtoreg;
   assign valid_o      = stage_q.valid;
   assign hazard_o     = hazard;
   assign bubble_cnt_o = 16'(bubble_cnt_q);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus queues expected outputs, a negedge monitor
// pops and compares. A second instance with a 3-bit counter exercises saturation.
module tb_id_ex_operand_stage;
   localparam int unsigned XLEN = 32;
   localparam int unsigned REGA = 5;

   localparam logic [7:0] MD1 = 8'h01, MD2 = 8'h02, MSD = 8'h04, MCTRL = 8'h08;
   localparam logic [7:0] MRD = 8'h10, MFL = 8'h20, MCNT = 8'h40, MCNTS = 8'h80, MALL = 8'hFF;
   localparam logic [5:0] FV = 6'b100000, FRW = 6'b010000, FMR = 6'b001000;
   localparam logic [5:0] FMT = 6'b000010, FHZ = 6'b000001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_i, id_valid_i, id_alusrc_i, id_uses_rs2_i;
   logic [REGA-1:0] id_rs1_i, id_rs2_i, id_rd_i, exmem_rd_i, memwb_rd_i;
   logic [XLEN-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, exmem_result_i, memwb_result_i;
   logic [3:0]      id_ctrl_i;
   logic            id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
   logic            exmem_regwrite_i, memwb_regwrite_i, stall_i, flush_i;

   logic [XLEN-1:0] data1_o, data2_o, store_data_o, s_data1, s_data2, s_store;
   logic [3:0]      ctrl_o, s_ctrl;
   logic [REGA-1:0] rd_o, s_rd;
   logic            regwrite_o, memread_o, memwrite_o, memtoreg_o, valid_o, hazard_o;
   logic            s_regwrite, s_memread, s_memwrite, s_memtoreg, s_valid, s_hazard;
   logic [15:0]     bubble_cnt_o, s_cnt;

   id_ex_operand_stage dut (
      .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
      .id_rs2_i(id_rs2_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
      .id_imm_i(id_imm_i), .id_alusrc_i(id_alusrc_i), .id_uses_rs2_i(id_uses_rs2_i),
      .id_ctrl_i(id_ctrl_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
      .id_memtoreg_i(id_memtoreg_i), .exmem_regwrite_i(exmem_regwrite_i),
      .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
      .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
      .memwb_result_i(memwb_result_i), .stall_i(stall_i), .flush_i(flush_i),
      .data1_o(data1_o), .data2_o(data2_o), .ctrl_o(ctrl_o), .store_data_o(store_data_o),
      .rd_o(rd_o), .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
      .memtoreg_o(memtoreg_o), .valid_o(valid_o), .hazard_o(hazard_o),
      .bubble_cnt_o(bubble_cnt_o)
   );

   id_ex_operand_stage #(.CntW(3)) dut_s (
      .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
      .id_rs2_i(id_rs2_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
      .id_imm_i(id_imm_i), .id_alusrc_i(id_alusrc_i), .id_uses_rs2_i(id_uses_rs2_i),
      .id_ctrl_i(id_ctrl_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
      .id_memtoreg_i(id_memtoreg_i), .exmem_regwrite_i(exmem_regwrite_i),
      .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
      .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
      .memwb_result_i(memwb_result_i), .stall_i(stall_i), .flush_i(flush_i),
      .data1_o(s_data1), .data2_o(s_data2), .ctrl_o(s_ctrl), .store_data_o(s_store),
      .rd_o(s_rd), .regwrite_o(s_regwrite), .memread_o(s_memread), .memwrite_o(s_memwrite),
      .memtoreg_o(s_memtoreg), .valid_o(s_valid), .hazard_o(s_hazard), .bubble_cnt_o(s_cnt)
   );

   typedef struct {
      string       name;
      logic [7:0]  mask;
      logic [31:0] d1, d2, sd;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic [5:0]  flags;
      logic [15:0] cnt, cnt_s;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.mask[0]) cmp(e.name, "data1", data1_o, e.d1);
         if (e.mask[1]) cmp(e.name, "data2", data2_o, e.d2);
         if (e.mask[2]) cmp(e.name, "store_data", store_data_o, e.sd);
         if (e.mask[3]) cmp(e.name, "ctrl", {28'b0, ctrl_o}, {28'b0, e.ctrl});
         if (e.mask[4]) cmp(e.name, "rd", {27'b0, rd_o}, {27'b0, e.rd});
         if (e.mask[5]) cmp(e.name, "flags", {26'b0, valid_o, regwrite_o, memread_o,
                                               memwrite_o, memtoreg_o, hazard_o},
                            {26'b0, e.flags});
         if (e.mask[6]) cmp(e.name, "bubble_cnt", {16'b0, bubble_cnt_o}, {16'b0, e.cnt});
         if (e.mask[7]) cmp(e.name, "bubble_cnt_small", {16'b0, s_cnt}, {16'b0, e.cnt_s});
      end
   end

   task automatic expect_out(input string nm, input logic [7:0] mask, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] sd,
                             input logic [3:0] ctrl, input logic [4:0] rd,
                             input logic [5:0] flags, input logic [15:0] cnt,
                             input logic [15:0] cnt_s);
      exp_t e;
      e.name = nm; e.mask = mask; e.d1 = d1; e.d2 = d2; e.sd = sd; e.ctrl = ctrl;
      e.rd = rd; e.flags = flags; e.cnt = cnt; e.cnt_s = cnt_s;
      sb_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic id_idle();
      id_valid_i = 0; id_rs1_i = '0; id_rs2_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0;
      id_imm_i = '0; id_alusrc_i = 0; id_uses_rs2_i = 0; id_ctrl_i = '0; id_rd_i = '0;
      id_regwrite_i = 0; id_memread_i = 0; id_memwrite_i = 0; id_memtoreg_i = 0;
   endtask

   task automatic fwd_idle();
      exmem_regwrite_i = 0; exmem_rd_i = '0; exmem_result_i = '0;
      memwb_regwrite_i = 0; memwb_rd_i = '0; memwb_result_i = '0;
   endtask

   // LW x5, 4(x2) with x2 = 0x100
   task automatic id_lw();
      id_idle();
      id_valid_i = 1; id_rs1_i = 5'd2; id_rs1_data_i = 32'h100; id_imm_i = 32'd4;
      id_alusrc_i = 1; id_ctrl_i = 4'h2; id_rd_i = 5'd5;
      id_regwrite_i = 1; id_memread_i = 1; id_memtoreg_i = 1;
   endtask

   // ADD x10, rs1, rs2 with stale register data (rs1 reads 1, rs2 reads 0)
   task automatic id_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses);
      id_idle();
      id_valid_i = 1; id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = uses;
      id_rs1_data_i = 32'd1; id_ctrl_i = 4'h0; id_rd_i = 5'd10; id_regwrite_i = 1;
   endtask

   initial begin
      // Reset with random inputs on every port
      rst_i = 1; stall_i = 1'($urandom); flush_i = 1'($urandom);
      id_valid_i = 1'($urandom); id_rs1_i = 5'($urandom); id_rs2_i = 5'($urandom);
      id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
      id_alusrc_i = 1'($urandom); id_uses_rs2_i = 1'($urandom); id_ctrl_i = 4'($urandom);
      id_rd_i = 5'($urandom); id_regwrite_i = 1'($urandom); id_memread_i = 1'($urandom);
      id_memwrite_i = 1'($urandom); id_memtoreg_i = 1'($urandom);
      exmem_regwrite_i = 1'($urandom); exmem_rd_i = 5'($urandom); exmem_result_i = $urandom;
      memwb_regwrite_i = 1'($urandom); memwb_rd_i = 5'($urandom); memwb_result_i = $urandom;
      cyc();
      expect_out("reset_1", MALL, 0, 0, 0, 0, 0, 6'b0, 0, 0);
      cyc();
      rst_i = 0; stall_i = 0; flush_i = 0; id_idle(); fwd_idle();
      expect_out("reset_2", MALL, 0, 0, 0, 0, 0, 6'b0, 0, 0);
      cyc();

      // ADDI x7, x3, 5 with x3 = 0x10
      id_valid_i = 1; id_rs1_i = 5'd3; id_rs1_data_i = 32'h10; id_imm_i = 32'd5;
      id_alusrc_i = 1; id_ctrl_i = 4'h2; id_rd_i = 5'd7; id_regwrite_i = 1;
      cyc();
      id_idle();
      expect_out("addi", MALL, 32'h10, 32'h5, 32'h0, 4'h2, 5'd7, FV | FRW, 0, 0);
      cyc();

      // Forwarding, observed while the stage is stalled
      id_valid_i = 1; id_rs1_i = 5'd4; id_rs1_data_i = 32'h11; id_rs2_i = 5'd6;
      id_rs2_data_i = 32'h66; id_uses_rs2_i = 1; id_ctrl_i = 4'h1; id_rd_i = 5'd8;
      id_regwrite_i = 1;
      cyc();
      id_idle(); stall_i = 1;
      exmem_regwrite_i = 1; exmem_rd_i = 5'd4; exmem_result_i = 32'hAA;
      memwb_regwrite_i = 1; memwb_rd_i = 5'd4; memwb_result_i = 32'hBB;
      expect_out("fwd_exmem", MD1 | MD2 | MSD | MCTRL, 32'hAA, 32'h66, 32'h66, 4'h1, 0, 0, 0, 0);
      cyc();
      exmem_regwrite_i = 0;
      expect_out("fwd_memwb", MD1 | MD2 | MSD | MCTRL, 32'hBB, 32'h66, 32'h66, 4'h1, 0, 0, 0, 0);
      cyc();
      exmem_regwrite_i = 1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
      expect_out("fwd_x0", MD1 | MD2 | MSD, 32'h11, 32'h66, 32'h66, 0, 0, 0, 0, 0);
      cyc();
      exmem_regwrite_i = 0; memwb_rd_i = 5'd6; memwb_result_i = 32'hCC;
      expect_out("fwd_rs2_memwb", MD1 | MD2 | MSD, 32'h11, 32'hCC, 32'hCC, 0, 0, 0, 0, 0);
      cyc();
      exmem_regwrite_i = 1; exmem_rd_i = 5'd6; exmem_result_i = 32'hDD;
      expect_out("fwd_rs2_prio", MD1 | MD2 | MSD, 32'h11, 32'hDD, 32'hDD, 0, 0, 0, 0, 0);
      cyc();
      stall_i = 0; fwd_idle();
      cyc();

      // Load followed by an instruction that does not read rs2: no hazard
      id_lw();
      cyc();
      id_add(5'd1, 5'd5, 1'b0);
      expect_out("no_hazard_rs2", MRD | MFL | MCNT, 0, 0, 0, 0, 5'd5, FV | FRW | FMR | FMT, 0, 0);
      cyc();

      // Load-use: exactly one bubble, then the load value arrives via MEM/WB
      id_lw();
      cyc();
      id_add(5'd1, 5'd5, 1'b1);
      expect_out("load_use", MRD | MFL | MCNT | MCNTS, 0, 0, 0, 0, 5'd5,
                 FV | FRW | FMR | FMT | FHZ, 0, 0);
      cyc();
      expect_out("bubble", MALL, 0, 0, 0, 0, 0, 6'b0, 16'd1, 16'd1);
      cyc();
      id_idle();
      memwb_regwrite_i = 1; memwb_rd_i = 5'd5; memwb_result_i = 32'h555;
      expect_out("after_bubble", MALL, 32'h1, 32'h555, 32'h555, 4'h0, 5'd10, FV | FRW,
                 16'd1, 16'd1);
      cyc();
      fwd_idle();

      // Stall holds the load and the hazard without counting; flush beats stall
      id_lw();
      cyc();
      id_add(5'd5, 5'd0, 1'b0); stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         expect_out("stall_hazard", MALL, 32'h100, 32'h4, 32'h0, 4'h2, 5'd5,
                    FV | FRW | FMR | FMT | FHZ, 16'd1, 16'd1);
         cyc();
      end
      flush_i = 1;
      expect_out("flush_stall_cycle", MALL, 32'h100, 32'h4, 32'h0, 4'h2, 5'd5,
                 FV | FRW | FMR | FMT | FHZ, 16'd1, 16'd1);
      cyc();
      flush_i = 0; stall_i = 0; id_idle();
      expect_out("flushed", MALL, 0, 0, 0, 0, 0, 6'b0, 16'd1, 16'd1);
      cyc();

      // Reset while stalled
      id_lw();
      cyc();
      id_idle(); stall_i = 1; rst_i = 1;
      cyc();
      rst_i = 0;
      expect_out("rst_mid_stall", MALL, 0, 0, 0, 0, 0, 6'b0, 0, 0);
      cyc();
      stall_i = 0;

      // Nine bubbles: wide counter reads 9, 3-bit counter sticks at 7
      for (int i = 0; i < 9; i++) begin
         id_lw();
         cyc();
         id_add(5'd5, 5'd0, 1'b0);
         cyc();
      end
      id_idle();
      expect_out("saturate", MFL | MCNT | MCNTS, 0, 0, 0, 0, 0, 6'b0, 16'd9, 16'd7);
      cyc();

      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
